// File: rtl/axi_stream_dma_pkg.sv
// Shared constants and request/response record types for the AXI4 <-> AXI-Stream DMA bridge.
package axi_stream_dma_pkg;

    localparam int PKG_ID_W  = 16;
    localparam int PKG_LEN_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [PKG_ID_W-1:0]  id;
        logic [PKG_LEN_W-1:0] len;
    } aw_req_t;

    typedef struct packed {
        logic [PKG_ID_W-1:0]  id;
        logic [PKG_LEN_W-1:0] len;
    } ar_req_t;

    typedef struct packed {
        logic [PKG_ID_W-1:0] id;
        logic [1:0]          resp;
    } b_rsp_t;

endpackage

// File: rtl/sync_req_fifo.sv
// Register-based show-ahead FIFO; a push while full is accepted when a pop happens in the same cycle.
module sync_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/axi_stream_dma_bridge.sv
// AXI4 slave that streams write bursts out on m_axis and returns s_axis data as read bursts,
// tracking burst boundaries from AWLEN/ARLEN to generate BID/BRESP and RID/RLAST.
module axi_stream_dma_bridge
    import axi_stream_dma_pkg::*;
#(
    parameter int DATA_W   = 512,
    parameter int ID_W     = 16,
    parameter int ADDR_W   = 64,
    parameter int LEN_W    = 8,
    parameter int AW_DEPTH = 8,
    parameter int AR_DEPTH = 8,
    parameter int B_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [LEN_W-1:0]    s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [LEN_W-1:0]    s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [31:0]         wr_bursts_done,
    output logic [31:0]         rd_bursts_done,
    output logic [15:0]         wlast_err_cnt
);

    // Handshake rule on every channel: a transfer happens in a cycle where valid and ready are
    // both high at the rising edge; neither side waits on the other's valid/ready combinationally
    // except the stream paths, which are pure pass-through qualified by burst bookkeeping.

    localparam int REQ_W = ID_W + LEN_W;
    localparam int RSP_W = ID_W + 2;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    logic              w_run;
    logic              w_unused;

    logic              w_aw_push, w_aw_pop, w_aw_full, w_aw_empty;
    logic [REQ_W-1:0]  w_aw_head;
    logic [ID_W-1:0]   w_aw_head_id;
    logic [LEN_W-1:0]  w_aw_head_len;

    logic              w_b_push, w_b_pop, w_b_full, w_b_empty;
    logic [RSP_W-1:0]  w_b_head;
    logic [1:0]        w_b_resp;

    logic              w_ar_push, w_ar_pop, w_ar_full, w_ar_empty;
    logic [REQ_W-1:0]  w_ar_head;
    logic [ID_W-1:0]   w_ar_head_id;
    logic [LEN_W-1:0]  w_ar_head_len;

    logic [LEN_W-1:0]  r_w_beat;
    logic              r_w_err;
    logic [LEN_W-1:0]  r_r_beat;
    logic [31:0]       r_wr_done;
    logic [31:0]       r_rd_done;
    logic [15:0]       r_wlast_err;

    logic              w_is_last_beat, w_w_gate, w_w_fire, w_w_done, w_wlast_err;
    logic              w_r_last, w_r_fire, w_r_done;

    // Addresses and sizes are accepted but play no part in routing.
    assign w_unused = ^{s_awaddr, s_awsize, s_araddr, s_arsize};

    // Holding every ready/valid low while reset is asserted keeps the interface quiet.
    assign w_run = !reset;

    // ---------------- Write address queue ----------------
    assign s_awready = w_run && !w_aw_full;
    assign w_aw_push = s_awvalid && s_awready;
    assign {w_aw_head_id, w_aw_head_len} = w_aw_head;

    sync_req_fifo #(.WIDTH(REQ_W), .DEPTH(AW_DEPTH)) u_aw_q (
        .clk(clk), .reset(reset),
        .i_push(w_aw_push), .i_data({s_awid, s_awlen}), .i_pop(w_aw_pop),
        .o_data(w_aw_head), .o_full(w_aw_full), .o_empty(w_aw_empty)
    );

    // ---------------- Write data path ----------------
    // The last beat of a burst is stalled if its response has nowhere to go.
    assign w_is_last_beat = (r_w_beat == w_aw_head_len);
    assign w_w_gate       = w_run && !w_aw_empty && !(w_is_last_beat && w_b_full);
    assign s_wready       = m_axis_tready && w_w_gate;
    assign m_axis_tvalid  = s_wvalid && w_w_gate;
    assign m_axis_tdata   = s_wdata;
    assign m_axis_tkeep   = s_wstrb;
    assign m_axis_tlast   = s_wlast;

    assign w_w_fire    = s_wvalid && s_wready;
    assign w_w_done    = w_w_fire && w_is_last_beat;
    assign w_wlast_err = w_w_fire && (s_wlast != w_is_last_beat);
    assign w_aw_pop    = w_w_done;
    // An early WLAST earlier in the burst poisons the final response as well.
    assign w_b_resp    = (r_w_err || !s_wlast) ? RESP_SLVERR : RESP_OKAY;

    // Beat position and sticky WLAST error for the head write burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_beat <= '0;
            r_w_err  <= 1'b0;
        end else if (w_w_done) begin
            r_w_beat <= '0;
            r_w_err  <= 1'b0;
        end else if (w_w_fire) begin
            r_w_beat <= r_w_beat + LEN_ONE;
            r_w_err  <= r_w_err || w_wlast_err;
        end
    end

    // ---------------- Write response queue ----------------
    assign w_b_push = w_w_done;
    assign w_b_pop  = s_bvalid && s_bready;
    assign s_bvalid = w_run && !w_b_empty;
    assign {s_bid, s_bresp} = w_b_head;

    sync_req_fifo #(.WIDTH(RSP_W), .DEPTH(B_DEPTH)) u_b_q (
        .clk(clk), .reset(reset),
        .i_push(w_b_push), .i_data({w_aw_head_id, w_b_resp}), .i_pop(w_b_pop),
        .o_data(w_b_head), .o_full(w_b_full), .o_empty(w_b_empty)
    );

    // ---------------- Read address queue ----------------
    assign s_arready = w_run && !w_ar_full;
    assign w_ar_push = s_arvalid && s_arready;
    assign {w_ar_head_id, w_ar_head_len} = w_ar_head;

    sync_req_fifo #(.WIDTH(REQ_W), .DEPTH(AR_DEPTH)) u_ar_q (
        .clk(clk), .reset(reset),
        .i_push(w_ar_push), .i_data({s_arid, s_arlen}), .i_pop(w_ar_pop),
        .o_data(w_ar_head), .o_full(w_ar_full), .o_empty(w_ar_empty)
    );

    // ---------------- Read data path ----------------
    // Without an outstanding read the stream is back-pressured, so no data is lost.
    assign s_rvalid      = w_run && s_axis_tvalid && !w_ar_empty;
    assign s_axis_tready = w_run && s_rready && !w_ar_empty;
    assign s_rdata       = s_axis_tdata;
    assign s_rid         = w_ar_head_id;
    assign s_rresp       = RESP_OKAY;
    assign w_r_last      = (r_r_beat == w_ar_head_len);
    assign s_rlast       = w_r_last;

    assign w_r_fire = s_rvalid && s_rready;
    assign w_r_done = w_r_fire && w_r_last;
    assign w_ar_pop = w_r_done;

    // Beat position within the head read burst.
    always_ff @(posedge clk) begin
        if (reset)         r_r_beat <= '0;
        else if (w_r_done) r_r_beat <= '0;
        else if (w_r_fire) r_r_beat <= r_r_beat + LEN_ONE;
    end

    // Burst completion counters (wrapping) and saturating WLAST error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_done   <= '0;
            r_rd_done   <= '0;
            r_wlast_err <= '0;
        end else begin
            if (w_w_done) r_wr_done <= r_wr_done + 32'd1;
            if (w_r_done) r_rd_done <= r_rd_done + 32'd1;
            if (w_wlast_err && (r_wlast_err != 16'hFFFF)) r_wlast_err <= r_wlast_err + 16'd1;
        end
    end

    assign wr_bursts_done = r_wr_done;
    assign rd_bursts_done = r_rd_done;
    assign wlast_err_cnt  = r_wlast_err;

endmodule

// File: tb/tb_axi_stream_dma_bridge.sv
// Bench for axi_stream_dma_bridge: reset checks, a directed vector table, hand-written corner
// sequences and a randomized phase, all compared against a queue-based reference model.
module tb_axi_stream_dma_bridge;

    localparam int DATA_W   = 64;
    localparam int ID_W     = 16;
    localparam int ADDR_W   = 64;
    localparam int LEN_W    = 8;
    localparam int AW_DEPTH = 8;
    localparam int AR_DEPTH = 8;
    localparam int B_DEPTH  = 4;

    // ---------------- Clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [ID_W-1:0]     s_awid, s_arid, s_bid, s_rid;
    logic [ADDR_W-1:0]   s_awaddr, s_araddr;
    logic [LEN_W-1:0]    s_awlen, s_arlen;
    logic [2:0]          s_awsize, s_arsize;
    logic                s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [DATA_W-1:0]   s_wdata, s_rdata, m_axis_tdata, s_axis_tdata;
    logic [DATA_W/8-1:0] s_wstrb, m_axis_tkeep;
    logic [1:0]          s_bresp, s_rresp;
    logic                s_bvalid, s_bready, s_arvalid, s_arready;
    logic                s_rlast, s_rvalid, s_rready;
    logic                m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic                s_axis_tvalid, s_axis_tready;
    logic [31:0]         wr_bursts_done, rd_bursts_done;
    logic [15:0]         wlast_err_cnt;

    axi_stream_dma_bridge #(
        .DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .AW_DEPTH(AW_DEPTH), .AR_DEPTH(AR_DEPTH), .B_DEPTH(B_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .wr_bursts_done(wr_bursts_done), .rd_bursts_done(rd_bursts_done),
        .wlast_err_cnt(wlast_err_cnt)
    );

    // ---------------- Reference model (burst-level queues) ----------------
    typedef struct {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } req_t;

    req_t               aw_q[$];
    req_t               ar_q[$];
    logic [ID_W+1:0]    exp_q[$];      // expected B responses {id, resp}
    int                 m_w_beat, m_r_beat;
    bit                 m_w_err;
    logic [31:0]        m_wr_done, m_rd_done;
    logic [15:0]        m_err;
    bit                 p_awready, p_wready, p_tvalid, p_bvalid, p_arready, p_rvalid, p_stready;
    bit                 p_w_last_pos, p_r_last_pos;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit natural_wlast();
        return (aw_q.size() > 0) && (m_w_beat == int'(aw_q[0].len));
    endfunction

    // Predict every output from the queues and compare.
    task automatic model_check();
        bit gate;
        p_awready    = !reset && aw_q.size() < AW_DEPTH;
        p_w_last_pos = natural_wlast();
        gate         = !reset && aw_q.size() > 0 && !(p_w_last_pos && exp_q.size() == B_DEPTH);
        p_wready     = gate && m_axis_tready;
        p_tvalid     = gate && s_wvalid;
        p_bvalid     = !reset && exp_q.size() > 0;
        p_arready    = !reset && ar_q.size() < AR_DEPTH;
        p_rvalid     = !reset && ar_q.size() > 0 && s_axis_tvalid;
        p_stready    = !reset && ar_q.size() > 0 && s_rready;
        p_r_last_pos = (ar_q.size() > 0) && (m_r_beat == int'(ar_q[0].len));
        chk("awready", s_awready, p_awready);
        chk("wready", s_wready, p_wready);
        chk("tvalid", m_axis_tvalid, p_tvalid);
        if (p_tvalid) begin
            chk("tdata", m_axis_tdata, s_wdata);
            chk("tkeep", m_axis_tkeep, s_wstrb);
            chk("tlast", m_axis_tlast, s_wlast);
        end
        chk("bvalid", s_bvalid, p_bvalid);
        if (p_bvalid) begin
            chk("bid", s_bid, exp_q[0][ID_W+1:2]);
            chk("bresp", s_bresp, exp_q[0][1:0]);
        end
        chk("arready", s_arready, p_arready);
        chk("rvalid", s_rvalid, p_rvalid);
        chk("axis_tready", s_axis_tready, p_stready);
        if (p_rvalid) begin
            chk("rid", s_rid, ar_q[0].id);
            chk("rdata", s_rdata, s_axis_tdata);
            chk("rlast", s_rlast, p_r_last_pos);
            chk("rresp", s_rresp, 2'b00);
        end
        chk("wr_done", wr_bursts_done, m_wr_done);
        chk("rd_done", rd_bursts_done, m_rd_done);
        chk("wlast_err", wlast_err_cnt, m_err);
    endtask

    // Apply the handshakes that will happen at the coming edge.
    task automatic model_update();
        if (reset) begin
            aw_q.delete(); ar_q.delete(); exp_q.delete();
            m_w_beat = 0; m_r_beat = 0; m_w_err = 0;
            m_wr_done = 0; m_rd_done = 0; m_err = 0;
            return;
        end
        if (p_bvalid && s_bready) void'(exp_q.pop_front());
        if (s_wvalid && p_wready) begin
            if (s_wlast != p_w_last_pos) begin
                m_w_err = 1;
                if (m_err != 16'hFFFF) m_err++;
            end
            if (p_w_last_pos) begin
                exp_q.push_back({aw_q[0].id, (m_w_err ? 2'b10 : 2'b00)});
                void'(aw_q.pop_front());
                m_w_beat = 0;
                m_w_err = 0;
                m_wr_done++;
            end else begin
                m_w_beat++;
            end
        end
        if (s_awvalid && p_awready) aw_q.push_back('{s_awid, s_awlen});
        if (p_rvalid && s_rready) begin
            if (p_r_last_pos) begin
                void'(ar_q.pop_front());
                m_r_beat = 0;
                m_rd_done++;
            end else begin
                m_r_beat++;
            end
        end
        if (s_arvalid && p_arready) ar_q.push_back('{s_arid, s_arlen});
    endtask

    // ---------------- Driver tasks ----------------
    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd6;
        s_wvalid = 0; s_wlast = 0; s_wdata = '0; s_wstrb = '1;
        s_bready = 1;
        s_arvalid = 0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd6;
        s_rready = 0;
        m_axis_tready = 1;
        s_axis_tvalid = 0; s_axis_tdata = '0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic       awv;
        logic [7:0] awid;
        logic [7:0] awlen;
        logic       wv;
        logic       wl;
        logic       e_awr;
        logic       e_wr;
        logic       e_tv;
        logic       e_tl;
        logic       e_bv;
        logic [7:0] e_bid;
        logic [1:0] e_br;
        logic [31:0] e_wrd;
        logic [15:0] e_err;
    } vec_t;

    vec_t vecs[11];

    logic [15:0] exp_rid[6]  = '{16'd1, 16'd7, 16'd7, 16'd7, 16'd3, 16'd3};
    logic        exp_rlast[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ar_ids[3]   = '{16'd1, 16'd7, 16'd3};
    logic [7:0]  ar_lens[3]  = '{8'd0, 8'd2, 8'd1};
    logic [63:0] words[6];

    initial begin
        int beats;
        int cyc;
        logic [63:0] held;

        //           awv id len wv wl awr wr tv tl bv bid br wrd err
        vecs[0]  = '{1, 5, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0, 1, 0};
        vecs[6]  = '{1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 2, 2, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1};

        // ---- reset ----
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            settle();
            advance();
        end
        reset = 0;
        settle();
        chk("rst_awready", s_awready, 1);
        chk("rst_wready", s_wready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_wr_done", wr_bursts_done, 0);
        chk("rst_err", wlast_err_cnt, 0);
        advance();

        // ---- table: good 4-beat burst, then burst with early WLAST ----
        for (int i = 0; i < 11; i++) begin
            s_awvalid = vecs[i].awv;
            s_awid    = {8'd0, vecs[i].awid};
            s_awlen   = vecs[i].awlen;
            s_wvalid  = vecs[i].wv;
            s_wlast   = vecs[i].wl;
            s_wdata   = rnd64();
            settle();
            chk("vec_awready", s_awready, vecs[i].e_awr);
            chk("vec_wready", s_wready, vecs[i].e_wr);
            chk("vec_tvalid", m_axis_tvalid, vecs[i].e_tv);
            if (vecs[i].e_tv) chk("vec_tlast", m_axis_tlast, vecs[i].e_tl);
            chk("vec_bvalid", s_bvalid, vecs[i].e_bv);
            if (vecs[i].e_bv) begin
                chk("vec_bid", s_bid, {8'd0, vecs[i].e_bid});
                chk("vec_bresp", s_bresp, vecs[i].e_br);
            end
            chk("vec_wr_done", wr_bursts_done, vecs[i].e_wrd);
            chk("vec_err", wlast_err_cnt, vecs[i].e_err);
            advance();
        end
        idle();

        // ---- three read bursts with rready toggling ----
        for (int i = 0; i < 6; i++) words[i] = rnd64();
        for (int i = 0; i < 3; i++) begin
            s_arvalid = 1; s_arid = ar_ids[i]; s_arlen = ar_lens[i];
            settle();
            chk("ar_accept", s_arready, 1);
            advance();
        end
        s_arvalid = 0;
        beats = 0;
        cyc = 0;
        while (beats < 6 && cyc < 60) begin
            s_axis_tvalid = 1;
            s_axis_tdata  = words[beats];
            s_rready      = cyc[0];
            settle();
            if (s_rvalid && s_rready) begin
                chk("rseq_rid", s_rid, exp_rid[beats]);
                chk("rseq_rlast", s_rlast, exp_rlast[beats]);
                chk("rseq_rdata", s_rdata, words[beats]);
                beats++;
            end
            advance();
            cyc++;
        end
        chk("rseq_beats", beats, 6);
        idle();
        settle();
        chk("rseq_rd_done", rd_bursts_done, 3);
        advance();

        // ---- fill AW queue, then B back-pressure ----
        for (int i = 0; i < 8; i++) begin
            s_awvalid = 1; s_awid = 16'(16 + i); s_awlen = 0;
            settle();
            chk("awfill_ready", s_awready, 1);
            advance();
        end
        s_awid = 16'd99;
        settle();
        chk("awfull_ready", s_awready, 0);
        advance();
        s_awvalid = 0;
        s_bready = 0;
        s_wvalid = 1;
        s_wlast = 1;
        for (int c = 0; c < 7; c++) begin
            s_wdata = rnd64();
            settle();
            if (c == 0) chk("awready_still_low", s_awready, 0);
            if (c == 1) chk("awready_reassert", s_awready, 1);
            if (c < 4) chk("wready_b_room", s_wready, 1);
            else begin
                chk("wready_bfull", s_wready, 0);
                chk("bfull_bid", s_bid, 16);
            end
            advance();
        end
        s_bready = 1;
        for (int c = 0; c < 16; c++) begin
            s_wdata = rnd64();
            settle();
            advance();
        end
        idle();
        settle();
        chk("bp_wr_done", wr_bursts_done, 10);
        chk("bp_bvalid", s_bvalid, 0);
        advance();

        // ---- stream data held with no read outstanding ----
        held = rnd64();
        s_axis_tvalid = 1; s_axis_tdata = held; s_rready = 1;
        for (int c = 0; c < 20; c++) begin
            settle();
            chk("hold_tready", s_axis_tready, 0);
            chk("hold_rvalid", s_rvalid, 0);
            advance();
        end
        s_arvalid = 1; s_arid = 16'd9; s_arlen = 0;
        settle();
        chk("hold_ar_cycle_rvalid", s_rvalid, 0);
        advance();
        s_arvalid = 0;
        settle();
        chk("hold_rvalid_after_ar", s_rvalid, 1);
        chk("hold_rdata", s_rdata, held);
        chk("hold_rid", s_rid, 9);
        chk("hold_rlast", s_rlast, 1);
        advance();
        idle();
        settle();
        chk("hold_rd_done", rd_bursts_done, 4);
        advance();

        // ---- reset in the middle of a write burst ----
        s_awvalid = 1; s_awid = 16'd4; s_awlen = 3;
        settle();
        advance();
        s_awvalid = 0;
        s_wvalid = 1; s_wlast = 0;
        for (int c = 0; c < 2; c++) begin
            s_wdata = rnd64();
            settle();
            advance();
        end
        reset = 1;
        settle();
        advance();
        settle();
        chk("midrst_awready", s_awready, 0);
        chk("midrst_wready", s_wready, 0);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_bvalid", s_bvalid, 0);
        chk("midrst_wr_done", wr_bursts_done, 0);
        chk("midrst_rd_done", rd_bursts_done, 0);
        advance();
        reset = 0;
        s_wvalid = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("midrst_no_b", s_bvalid, 0);
            advance();
        end
        s_awvalid = 1; s_awid = 16'd6; s_awlen = 1;
        settle();
        advance();
        s_awvalid = 0;
        s_wvalid = 1;
        for (int c = 0; c < 2; c++) begin
            s_wlast = (c == 1);
            s_wdata = rnd64();
            settle();
            chk("post_rst_wready", s_wready, 1);
            advance();
        end
        s_wvalid = 0;
        settle();
        chk("post_rst_bvalid", s_bvalid, 1);
        chk("post_rst_bid", s_bid, 6);
        chk("post_rst_bresp", s_bresp, 0);
        chk("post_rst_wr_done", wr_bursts_done, 1);
        advance();
        idle();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 800; c++) begin
            s_awvalid = ($urandom_range(0, 3) == 0);
            s_awid    = 16'($urandom);
            s_awlen   = 8'($urandom_range(0, 3));
            s_wvalid  = $urandom_range(0, 1);
            s_wdata   = rnd64();
            s_wstrb   = 8'($urandom);
            s_wlast   = ($urandom_range(0, 7) == 0) ? !natural_wlast() : natural_wlast();
            s_bready  = ($urandom_range(0, 3) != 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            s_arvalid = ($urandom_range(0, 3) == 0);
            s_arid    = 16'($urandom);
            s_arlen   = 8'($urandom_range(0, 3));
            s_axis_tvalid = $urandom_range(0, 1);
            s_axis_tdata  = rnd64();
            s_rready  = $urandom_range(0, 1);
            settle();
            advance();
        end
        idle();
        settle();
        advance();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/axi_stream_dma_bridge.md
Name: axi_stream_dma_bridge

Overview:
Parametrised AXI4 slave that connects the buffered PCIS DMA bus to a pair of AXI-Stream channels: the write path feeds the accelerator input stream, and the read path returns the accelerator output stream. It replaces fixed-tieoff bridging with proper burst tracking, which gives per-burst RID/RLAST from ARLEN, BID/BRESP from AWID/WLAST, and backpressure-safe request queues. It sits between the AXI register slice and the width converters/FIFOs around the CNN.

Parameters:
DATA_W, 512, AXI data and stream width in bits (multiple of 8)
ID_W, 16, AXI ID width
ADDR_W, 64, AXI address width (address accepted, not used for routing)
LEN_W, 8, AXI burst length field width
AW_DEPTH, 8, outstanding write bursts (power of 2, >=2)
AR_DEPTH, 8, outstanding read bursts (power of 2, >=2)
B_DEPTH, 4, queued write responses (power of 2, >=2)

Ports:
clk  in  1  single clock domain
reset  in  1  synchronous, active-high
s_awid/s_awaddr/s_awlen/s_awsize  in  ID_W/ADDR_W/LEN_W/3  AW payload
s_awvalid in 1; s_awready out 1  AW handshake
s_wdata/s_wstrb/s_wlast  in  DATA_W/DATA_W/8/1  W payload
s_wvalid in 1; s_wready out 1  W handshake
s_bid/s_bresp  out  ID_W/2  B payload
s_bvalid out 1; s_bready in 1  B handshake
s_arid/s_araddr/s_arlen/s_arsize  in  ID_W/ADDR_W/LEN_W/3  AR payload
s_arvalid in 1; s_arready out 1  AR handshake
s_rid/s_rdata/s_rresp/s_rlast  out  ID_W/DATA_W/2/1  R payload
s_rvalid out 1; s_rready in 1  R handshake
m_axis_tdata/m_axis_tkeep/m_axis_tlast  out  DATA_W/DATA_W/8/1  write stream to accelerator
m_axis_tvalid out 1; m_axis_tready in 1
s_axis_tdata  in  DATA_W  read stream from accelerator
s_axis_tvalid in 1; s_axis_tready out 1
wr_bursts_done  out  32  completed write bursts (wraps)
rd_bursts_done  out  32  completed read bursts (wraps)
wlast_err_cnt  out  16  WLAST mismatches (saturates at 16'hFFFF)

Behaviour:
- Reset: all valids/readys low; counters 0; all queues empty; beat counters 0. Reset mid-burst drops every queue and partial burst; no B or R is emitted for bursts that were in flight.
- AW queue: s_awready = !aw_full; a push stores {awid, awlen}. Push and pop in the same cycle while full is legal.
- W path: combinational pass-through, m_axis_tdata=s_wdata, tkeep=s_wstrb, tlast=s_wlast. s_wready = m_axis_tready & aw_nonempty & !(is_last_beat & b_full); m_axis_tvalid mirrors s_wvalid under the same qualifiers.
- W path beat tracking: w_beat counts accepted beats of the head burst; is_last_beat = (w_beat == head awlen).
- On the last accepted beat: pop AW, clear w_beat, push B {head awid, resp}. resp = 2'b00 if s_wlast==1, else 2'b10 (SLVERR) with wlast_err_cnt +1.
- Early WLAST (wlast=1 before the last beat): the beat is forwarded, the burst continues, and one error is counted; the final B is SLVERR.
- B queue: s_bvalid = b_nonempty, popped on s_bvalid&s_bready. Payload is registered and stays stable while stalled. wr_bursts_done +1 per B push.
- AR queue: s_arready = !ar_full; a push stores {arid, arlen}.
- R path: s_rvalid = s_axis_tvalid & ar_nonempty; s_axis_tready = s_rready & ar_nonempty; s_rdata = s_axis_tdata; s_rid = head arid; s_rresp=2'b00.
- R path beat tracking: s_rlast = (r_beat == head arlen); r_beat increments per R handshake; on the last beat, pop AR, clear r_beat, rd_bursts_done +1.
- With no AR outstanding, stream data is held, never dropped.
- Latency: W→stream and stream→R are 0 cycles (combinational data). AW push to W acceptance is 1 cycle (queue registered). Last W beat to BVALID is 1 cycle.
- Simultaneous events: AW push and pop in the same cycle keeps occupancy; same for AR. B push and pop in the same cycle keeps occupancy.
- awlen=0 / arlen=0: single-beat burst; the first beat is last.
- Wrap-around: the 32-bit done counters wrap mod 2^32.

Decomposition:
- Package axi_stream_dma_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the typedef structs aw_req_t {id,len}, ar_req_t {id,len}, b_rsp_t {id,resp}, parametrised via localparam widths matching the defaults.
- One sub-module, sync_req_fifo: generic WIDTH/DEPTH register FIFO with full/empty, used for the AW, AR and B queues; it has show-ahead output and supports simultaneous push/pop when full.

Test Plan:
- AW id=5 len=3, 4 W beats with wlast on beat 4, tready=1 → 4 stream beats with tlast on the 4th; one B id=5 resp=00 one cycle after the last beat; wr_bursts_done=1.
- AW id=2 len=1, wlast asserted on beat 1 and 2 → both forwarded; B id=2 resp=10; wlast_err_cnt=1.
- Three ARs (id 1 len0, id 7 len2, id 3 len1), 6 stream beats, rready toggled 50% → R ids 1,7,7,7,3,3 with rlast on beats 1,4,6; data order preserved; rd_bursts_done=3.
- Fill AW queue with 8 requests and no W → awready low after 8; the first completed burst reasserts awready the next cycle. Hold bready=0 for 4 bursts → wready low on the 5th burst's last beat.
- Stream valid with no AR outstanding → tready=0 and rvalid=0 for 20 cycles; an AR len=0 arrives → one R beat with that data.
- Reset asserted mid write burst (beat 2 of 4) → all outputs at reset values next cycle; no B ever issued; a new burst afterwards completes normally.
